uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 98 +++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte FIFO placed behind a UART receiver. Bytes are written on
// the one-cycle rx_done strobe and presented first-word fall-through to the
// consumer with a valid/ready handshake. A sticky overrun flag records any
// byte dropped because the FIFO was full.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   wr_data      received byte
//   wr_en        one-cycle write strobe
//   rd_data      oldest stored byte (valid when rd_valid=1)
//   rd_valid     FIFO holds at least one byte
//   rd_ready     consumer accepts rd_data this cycle
//   count        number of stored bytes, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AF_LEVEL
//   overrun      sticky: a byte was dropped while full
//   ovr_clr      synchronous clear for overrun
module uart_rx_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_en,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic                       overrun,
   input  logic                       ovr_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              rd_acc;
   logic              wr_acc;
   logic              drop;

   // Status flags decode only the registered count, so no input reaches them.
   assign empty       = (count == '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign almost_full = (count >= CNT_W'(AF_LEVEL));
   assign rd_valid    = ~empty;
   assign rd_data     = mem[rd_ptr];

   // A full FIFO still takes a write when the same edge frees a slot.
   assign rd_acc = rd_valid & rd_ready;
   assign wr_acc = wr_en & (~full | rd_acc);
   assign drop   = wr_en & full & ~rd_acc;

   // Storage is never reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1 -> 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule
